// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
// Arbitrates the single GRF write port between the W stage (primary, always
// granted) and a small FIFO of slow-path writes (multi-cycle unit, late loads).
// The FIFO drains into cycles where the W stage does not write. If the head
// waits too long, pipe_stall asks the pipeline to freeze so the head can drain.
// pend_mask lists every register with a write still queued, so the D stage can
// stall on RAW/WAW hazards against those registers.
module grf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_we,
  input  logic [4:0]               p_addr,
  input  logic [31:0]              p_data,
  input  logic [31:0]              p_pc,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_addr,
  input  logic [31:0]              s_data,
  input  logic [31:0]              s_pc,
  output logic                     grf_we,
  output logic [4:0]               grf_a3,
  output logic [31:0]              grf_wd,
  output logic [31:0]              grf_pc,
  output logic                     pipe_stall,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(STARVE_LIMIT);

  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_occ;
  logic [CW-1:0] r_wait;

  logic          w_nonempty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pend;
  logic [AW-1:0] w_idx;

  // Ready depends only on registered occupancy, so a full FIFO refuses a push
  // even when it pops in the same cycle; gated off while reset is held.
  assign w_nonempty = (r_occ != '0);
  assign w_ready    = reset && (r_occ < OCC_FULL);
  // A $0 request completes its handshake but is dropped: writing $0 is a no-op.
  assign w_push     = s_valid && w_ready && (s_addr != 5'd0);
  // The head drains only into cycles the W stage leaves free.
  assign w_pop      = !p_we && w_nonempty;

  assign s_ready    = w_ready;
  assign occ        = r_occ;
  assign pipe_stall = (r_wait == WAIT_SAT);
  assign pend_mask  = w_pend;

  // Write-port select: primary first, then FIFO head, else idle; forced 0 in reset.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (reset) begin
      if (p_we) begin
        grf_we = 1'b1;
        grf_a3 = p_addr;
        grf_wd = p_data;
        grf_pc = p_pc;
      end else if (w_nonempty) begin
        grf_we = 1'b1;
        grf_a3 = r_addr[r_rd_ptr];
        grf_wd = r_data[r_rd_ptr];
        grf_pc = r_pc[r_rd_ptr];
      end
    end
  end

  // Pending mask: one-hot of every valid entry's destination, walked from the head.
  always_comb begin
    w_pend = 32'd0;
    w_idx  = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if (i < int'(r_occ)) begin
        w_pend[r_addr[w_idx]] = 1'b1;
      end
    end
    w_pend[0] = 1'b0;
  end

  // FIFO storage: written at the tail on an accepted, non-$0 push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
        r_pc[i]   <= 32'd0;
      end
    end else if (w_push) begin
      r_addr[r_wr_ptr] <= s_addr;
      r_data[r_wr_ptr] <= s_data;
      r_pc[r_wr_ptr]   <= s_pc;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occ holds 0..DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW + 1)'(1);
        2'b01:   r_occ <= r_occ - (AW + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Starvation timer: counts cycles a queued head is blocked, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_pop || !w_nonempty) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_SAT) begin
      r_wait <= r_wait + CW'(1);
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed stimulus; expected GRF writes are queued
// as they are scheduled and a negedge monitor compares each observed write.
module tb_grf_write_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_we = 1'b0;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_data = '0;
  logic [31:0] p_pc = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [4:0]  s_addr = '0;
  logic [31:0] s_data = '0;
  logic [31:0] s_pc = '0;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic        pipe_stall;
  logic [31:0] pend_mask;
  logic [2:0]  occ;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t m_e;

  grf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_pc(s_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic prim(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p_we = 1'b1; p_addr = a; p_data = d; p_pc = pc;
    q.push_back('{a, d, pc});
  endtask

  task automatic drain(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p_we = 1'b0;
    q.push_back('{a, d, pc});
  endtask

  task automatic spush(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    s_valid = 1'b1; s_addr = a; s_data = d; s_pc = pc;
  endtask

  // Scoreboard monitor: every GRF write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && grf_we === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual a3=%0d wd=%h pc=%h required none", grf_a3, grf_wd, grf_pc);
      end else begin
        m_e = q.pop_front();
        if (grf_a3 !== m_e.a || grf_wd !== m_e.d || grf_pc !== m_e.pc) begin
          errors++;
          $display("FAIL grf_write actual a3=%0d wd=%h pc=%h required a3=%0d wd=%h pc=%h",
                   grf_a3, grf_wd, grf_pc, m_e.a, m_e.d, m_e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) tick();
    smp();
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'(grf_we), 32'd0);
    tick(); reset = 1'b1;
    smp();
    chk("rel_ready", 32'(s_ready), 32'd1);

    // Priority: W stage write wins over a queued head
    tick(); spush(5'd6, 32'h22, 32'h100);
    tick(); s_valid = 1'b0; prim(5'd5, 32'h11, 32'h200);
    smp();
    chk("prio_occ", 32'(occ), 32'd1);
    chk("prio_pend", pend_mask, 32'h0000_0040);
    tick(); drain(5'd6, 32'h22, 32'h100);
    smp();
    tick(); p_we = 1'b0;
    smp();
    chk("prio_empty", 32'(occ), 32'd0);
    chk("prio_pend0", pend_mask, 32'd0);

    // Fill to full while the W stage writes every cycle
    for (int i = 0; i < 4; i++) begin
      tick(); prim(5'(1 + i), 32'hA0 + 32'(i), 32'h600 + 32'(i));
      spush(5'(10 + i), 32'h300 + 32'(i), 32'h400 + 32'(i));
    end
    tick(); prim(5'd5, 32'hA4, 32'h604); spush(5'd20, 32'h999, 32'h999);
    smp();
    chk("full_occ", 32'(occ), 32'd4);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_pend", pend_mask, 32'h0000_3C00);
    tick(); s_valid = 1'b0; prim(5'd6, 32'hA5, 32'h605);
    smp();
    chk("full_occ2", 32'(occ), 32'd4);
    chk("full_pend2", pend_mask, 32'h0000_3C00);

    // Drain two, then push+pop at occ=2 across the pointer wrap
    tick(); drain(5'd10, 32'h300, 32'h400);
    smp();
    tick(); drain(5'd11, 32'h301, 32'h401);
    smp();
    tick(); drain(5'd12, 32'h302, 32'h402); spush(5'd14, 32'h314, 32'h414);
    smp();
    chk("pp_occ_a", 32'(occ), 32'd2);
    chk("pp_ready", 32'(s_ready), 32'd1);
    tick(); drain(5'd13, 32'h303, 32'h403); spush(5'd15, 32'h315, 32'h415);
    smp();
    chk("pp_occ_b", 32'(occ), 32'd2);
    chk("pp_pend_b", pend_mask, 32'h0000_6000);
    tick(); s_valid = 1'b0; drain(5'd14, 32'h314, 32'h414);
    smp();
    chk("pp_occ_c", 32'(occ), 32'd2);
    chk("pp_pend_c", pend_mask, 32'h0000_C000);
    tick(); drain(5'd15, 32'h315, 32'h415);
    smp();
    chk("pp_occ_d", 32'(occ), 32'd1);
    tick(); p_we = 1'b0;
    smp();
    chk("pp_empty", 32'(occ), 32'd0);

    // Starvation: head blocked for STARVE_LIMIT cycles
    tick(); spush(5'd7, 32'h77, 32'h500);
    for (int k = 0; k < 8; k++) begin
      tick(); s_valid = 1'b0; prim(5'd2, 32'hB0 + 32'(k), 32'h700 + 32'(k));
      smp();
      chk("starve_pre", 32'(pipe_stall), 32'd0);
    end
    tick(); prim(5'd3, 32'hB8, 32'h708);
    smp();
    chk("starve_hit", 32'(pipe_stall), 32'd1);
    tick(); drain(5'd7, 32'h77, 32'h500);
    smp();
    chk("starve_sat", 32'(pipe_stall), 32'd1);
    tick(); p_we = 1'b0;
    smp();
    chk("starve_clr", 32'(pipe_stall), 32'd0);
    chk("starve_occ", 32'(occ), 32'd0);

    // $0 request: accepted but never stored or written
    tick(); spush(5'd0, 32'h99, 32'h990);
    smp();
    chk("zero_ready", 32'(s_ready), 32'd1);
    tick(); s_valid = 1'b0;
    smp();
    chk("zero_occ", 32'(occ), 32'd0);
    chk("zero_pend", pend_mask, 32'd0);
    chk("zero_we", 32'(grf_we), 32'd0);

    // Asynchronous reset mid-run with occ=3
    for (int i = 0; i < 3; i++) begin
      tick(); prim(5'(20 + i), 32'hC0 + 32'(i), 32'h800 + 32'(i));
      spush(5'(24 + i), 32'hD0 + 32'(i), 32'hE0 + 32'(i));
    end
    tick(); s_valid = 1'b0;
    p_we = 1'b1; p_addr = 5'd9; p_data = 32'hEE; p_pc = 32'h900;
    #1;
    chk("pre_rst_occ", 32'(occ), 32'd3);
    chk("pre_rst_pend", pend_mask, 32'h0700_0000);
    reset = 1'b0;
    #1;
    chk("ar_ready", 32'(s_ready), 32'd0);
    chk("ar_we", 32'(grf_we), 32'd0);
    chk("ar_a3", 32'(grf_a3), 32'd0);
    chk("ar_wd", grf_wd, 32'd0);
    chk("ar_pc", grf_pc, 32'd0);
    chk("ar_stall", 32'(pipe_stall), 32'd0);
    chk("ar_pend", pend_mask, 32'd0);
    chk("ar_occ", 32'(occ), 32'd0);
    tick(); reset = 1'b1; p_we = 1'b0;
    smp();
    chk("post_occ", 32'(occ), 32'd0);
    chk("post_ready", 32'(s_ready), 32'd1);
    chk("post_we", 32'(grf_we), 32'd0);

    repeat (2) tick();
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
